// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller with ready/ack memory handshake,
// pipeline stall, lane extraction and misalignment/timeout exception capture.
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] badvaddr,
    input  logic              exc_clear
);
    localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, EXC} ctrlState;

    ctrlState          state, stateNext;
    logic [ADDR_W-1:0] addrQ, pcQ, epcQ, badQ;
    logic [1:0]        sizeQ, causeQ;
    logic [31:0]       wdataQ, rdataQ, shifted, laneData;
    logic              writeQ, isNoop, misaligned, expired, inAccess;
    logic [CW-1:0]     waitCnt;
    logic [3:0]        beRaw;

    assign isNoop     = !req_read && !req_write;
    assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && |req_addr[1:0]);
    assign inAccess   = state == ACCESS;
    assign expired    = inAccess && !mem_ack && waitCnt == CW'(WAIT_MAX - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req_valid) stateNext = isNoop ? RESP : misaligned ? EXC : ACCESS;
            ACCESS:  stateNext = mem_ack ? RESP : expired ? EXC : ACCESS;
            RESP:    stateNext = IDLE;
            default: stateNext = exc_clear ? IDLE : EXC;
        endcase
    end

    // Shift the addressed lane down to bit 0; masks below zero-extend it.
    assign shifted  = mem_rdata >> {addrQ[1:0], 3'b000};
    assign laneData = sizeQ == 2'b00 ? shifted & 32'h0000_00FF :
                      sizeQ == 2'b01 ? shifted & 32'h0000_FFFF : mem_rdata;
    assign beRaw    = sizeQ == 2'b00 ? 4'b0001 << addrQ[1:0] :
                      sizeQ == 2'b01 ? (addrQ[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addrQ   <= '0;
            pcQ     <= '0;
            sizeQ   <= '0;
            wdataQ  <= '0;
            writeQ  <= 1'b0;
            rdataQ  <= '0;
            causeQ  <= '0;
            epcQ    <= '0;
            badQ    <= '0;
            waitCnt <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                addrQ  <= req_addr;
                pcQ    <= req_pc;
                sizeQ  <= req_size;
                wdataQ <= req_wdata;
                writeQ <= req_write;
                if (isNoop) begin
                    rdataQ <= '0;
                end else if (misaligned) begin
                    causeQ <= req_write ? 2'b10 : 2'b01;
                    epcQ   <= req_pc;
                    badQ   <= req_addr;
                end
            end
            if (inAccess) begin
                waitCnt <= mem_ack || expired ? '0 : waitCnt + CW'(1);
                if (mem_ack && !writeQ) rdataQ <= laneData;
                if (expired) begin
                    causeQ <= 2'b11;
                    epcQ   <= pcQ;
                    badQ   <= addrQ;
                end
            end
        end
    end

    assign req_ready = state == IDLE;
    assign stall     = inAccess || state == EXC;
    assign rsp_valid = state == RESP;
    assign rsp_rdata = rdataQ;
    assign mem_en    = inAccess;
    assign mem_we    = inAccess && writeQ;
    assign mem_be    = inAccess ? beRaw : 4'b0000;
    assign mem_addr  = {addrQ[ADDR_W-1:2], 2'b00};
    assign mem_wdata = sizeQ == 2'b00 ? {4{wdataQ[7:0]}} :
                       sizeQ == 2'b01 ? {2{wdataQ[15:0]}} : wdataQ;
    assign exc_valid = state == EXC;
    assign exc_cause = causeQ;
    assign epc       = epcQ;
    assign badvaddr  = badQ;
endmodule
